// File: rtl/obi_txn_tracker.sv
// obi_txn_tracker: grants OBI requests, forwards commands, tracks IDs in order and returns responses
module obi_txn_tracker #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_in,
    input  logic                      we_in,
    input  logic [ADDR_WIDTH-1:0]     addr_in,
    input  logic [DATA_WIDTH-1:0]     wdata_in,
    input  logic [ID_WIDTH-1:0]       aid_in,
    output logic                      gnt_out,
    output logic                      cmd_valid_out,
    output logic                      cmd_we_out,
    output logic [ADDR_WIDTH-1:0]     cmd_addr_out,
    output logic [DATA_WIDTH-1:0]     cmd_wdata_out,
    input  logic                      cmd_ready_in,
    input  logic                      done_in,
    input  logic [DATA_WIDTH-1:0]     ctrl_rdata_in,
    input  logic                      ctrl_err_in,
    output logic                      rvalid_out,
    output logic [DATA_WIDTH-1:0]     rdata_out,
    output logic                      err_out,
    output logic [ID_WIDTH-1:0]       rid_out,
    output logic [$clog2(DEPTH):0]    outstanding_out,
    output logic                      protocol_err_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ID_WIDTH:0]     mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  cmd_valid_q, cmd_we_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, rdata_q;
    logic                  rvalid_q, err_q, perr_q;
    logic [ID_WIDTH-1:0]   rid_q, head_id;
    logic                  head_we, hs, pop;

    // A full FIFO refuses new requests even when a pop lands in the same cycle
    assign gnt_out = !rst && req_in && (count_q != CW'(DEPTH)) && (!cmd_valid_q || cmd_ready_in);

    always_comb begin
        hs      = req_in && gnt_out;
        pop     = done_in && (count_q != '0);
        {head_id, head_we} = mem_q[rptr_q];
        count_d = count_q + CW'(hs) - CW'(pop);
    end

    always_ff @(posedge clk)
        if (hs) mem_q[wptr_q] <= {aid_in, we_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rid_q       <= '0;
            perr_q      <= 1'b0;
        end else begin
            if (hs) begin
                cmd_we_q    <= we_in;
                cmd_addr_q  <= addr_in;
                cmd_wdata_q <= wdata_in;
                wptr_q      <= wptr_q + 1'b1;
            end
            cmd_valid_q <= hs || (cmd_valid_q && !cmd_ready_in);
            if (pop) begin
                rptr_q  <= rptr_q + 1'b1;
                rid_q   <= head_id;
                err_q   <= ctrl_err_in;
                rdata_q <= head_we ? '0 : ctrl_rdata_in;
            end
            rvalid_q <= pop;
            count_q  <= count_d;
            if (done_in && count_q == '0) perr_q <= 1'b1;
        end
    end

    assign cmd_valid_out    = cmd_valid_q;
    assign cmd_we_out       = cmd_we_q;
    assign cmd_addr_out     = cmd_addr_q;
    assign cmd_wdata_out    = cmd_wdata_q;
    assign rvalid_out       = rvalid_q;
    assign rdata_out        = rdata_q;
    assign err_out          = err_q;
    assign rid_out          = rid_q;
    assign outstanding_out  = count_q;
    assign protocol_err_out = perr_q;
endmodule
